fpu_fp2int16: RTL and testbench

- Multi-cycle FP16 to signed int16 converter, the decode direction of the FPU datapath.
- Takes a packed fp16_t (sign/exp/frac), classifies it, aligns the significand with an iterative 1-bit-per-cycle shifter, and applies the sign.
- Emits int16 plus {Z,C,N,V} condition codes in the same condCode_t format as the add/sub unit.
- Sits beside fpuAddSub16 under the FPU top; valid/ready on both sides.

---
 rtl/fpu_fp2int16_pkg.sv | 58 +++++
 rtl/fpu_fp2int16_if.sv | 41 ++++
 rtl/fpu_fp2int16_classify.sv | 89 ++++++++
 rtl/fpu_fp2int16.sv | 219 +++++++++++++++++++++
 tb/tb_fpu_fp2int16.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_fp2int16_pkg.sv
// ---------------------------------------------------------------------------
// fpu_fp2int16_pkg
// Shared widths, constants and types for the FP16 -> int16 converter.
//   fp16_t      : packed half-precision operand {sign, exp[4:0], frac[9:0]}
//   condCode_t  : packed condition codes {Z, C, N, V}, same layout as add/sub
//   f2iState_t  : converter FSM states
//   f2iClass_t  : operand classes produced by the classifier
// ---------------------------------------------------------------------------
package fpu_fp2int16_pkg;

    localparam int FP16_EXPW    = 5;
    localparam int FP16_FRACW   = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;

    localparam logic [15:0] INT16_MAX = 16'h7FFF;
    localparam logic [15:0] INT16_MIN = 16'h8000;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXPW-1:0]  exp;
        logic [FP16_FRACW-1:0] frac;
    } fp16_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } condCode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } f2iState_t;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_NORMAL = 3'd1,
        CLS_INF    = 3'd2,
        CLS_NAN    = 3'd3,
        CLS_OVF    = 3'd4
    } f2iClass_t;

    // Z and N always follow the final 16-bit result; C and V come from the datapath.
    function automatic condCode_t make_cc(input logic [15:0] result,
                                          input logic        inexact,
                                          input logic        invalid);
        condCode_t cc;
        cc.z = (result == 16'h0000);
        cc.c = inexact;
        cc.n = result[15];
        cc.v = invalid;
        return cc;
    endfunction

endpackage

// File: rtl/fpu_fp2int16_if.sv
// ---------------------------------------------------------------------------
// fpu_fp2int16_if
// Valid/ready operand and result channels of the FP16 -> int16 converter.
//   inValid/inReady/fpuIn           : operand channel (producer -> converter)
//   outValid/outReady/intOut/condCodes : result channel (converter -> consumer)
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the converter
// ---------------------------------------------------------------------------
interface fpu_fp2int16_if;
    import fpu_fp2int16_pkg::*;

    logic        inValid;
    logic        inReady;
    fp16_t       fpuIn;
    logic        outValid;
    logic        outReady;
    logic [15:0] intOut;
    condCode_t   condCodes;

    modport master (
        output inValid,
        output fpuIn,
        output outReady,
        input  inReady,
        input  outValid,
        input  intOut,
        input  condCodes
    );

    modport slave (
        input  inValid,
        input  fpuIn,
        input  outReady,
        output inReady,
        output outValid,
        output intOut,
        output condCodes
    );

endinterface

// File: rtl/fpu_fp2int16_classify.sv
// ---------------------------------------------------------------------------
// fpu_fp2int16_classify
// Combinational classifier for an FP16 operand. Decides whether the value
// needs the iterative shifter (and in which direction / how many steps) or
// whether its integer result is known up front.
// Ports:
//   i_op          fp16_t operand
//   o_class       operand class (zero/normal/inf/nan/ovf)
//   o_shift_left  1 = significand shifts left, 0 = right
//   o_cnt         number of 1-bit shift steps (0..10)
//   o_preset_val  integer result for non-normal classes
//   o_preset_c    inexact flag for non-normal classes
//   o_preset_v    invalid/out-of-range flag for non-normal classes
// ---------------------------------------------------------------------------
module fpu_fp2int16_classify
    import fpu_fp2int16_pkg::*;
(
    input  fp16_t       i_op,
    output f2iClass_t   o_class,
    output logic        o_shift_left,
    output logic [3:0]  o_cnt,
    output logic [15:0] o_preset_val,
    output logic        o_preset_c,
    output logic        o_preset_v
);

    // Biased-exponent thresholds. Unbiased e = exp - 15:
    //   exp >= 30  -> e >= 15 (out of range except exactly -32768)
    //   exp >= 25  -> e >= 10 (significand shifts left by e-10)
    //   exp >= 15  -> e >= 0  (significand shifts right by 10-e)
    localparam logic [FP16_EXPW-1:0] EXP_ALL_ONES = FP16_EXPW'(FP16_EXP_MAX);
    localparam logic [FP16_EXPW-1:0] EXP_SAT      = FP16_EXPW'(FP16_BIAS + 15);
    localparam logic [FP16_EXPW-1:0] EXP_LSH      = FP16_EXPW'(FP16_BIAS + 10);
    localparam logic [FP16_EXPW-1:0] EXP_UNITY    = FP16_EXPW'(FP16_BIAS);

    // Shift counts only ever span 0..10, so 4-bit modular arithmetic on the
    // low exponent bits gives the exact result without a wider subtractor.
    localparam logic [3:0] LSH_BASE_LO = 4'(FP16_BIAS + 10);

    logic [3:0] w_lsh_cnt;
    logic [3:0] w_rsh_cnt;
    logic       w_frac_zero;

    assign w_lsh_cnt   = i_op.exp[3:0] - LSH_BASE_LO;
    assign w_rsh_cnt   = LSH_BASE_LO - i_op.exp[3:0];
    assign w_frac_zero = (i_op.frac == '0);

    always_comb begin
        o_class      = CLS_NORMAL;
        o_shift_left = 1'b0;
        o_cnt        = 4'd0;
        o_preset_val = 16'h0000;
        o_preset_c   = 1'b0;
        o_preset_v   = 1'b0;

        if (i_op.exp == EXP_ALL_ONES) begin
            if (w_frac_zero) begin
                o_class      = CLS_INF;
                o_preset_val = i_op.sign ? INT16_MIN : INT16_MAX;
            end else begin
                o_class      = CLS_NAN;
                o_preset_val = INT16_MIN;
            end
            o_preset_v = 1'b1;
        end else if (i_op.exp >= EXP_SAT) begin
            o_class = CLS_OVF;
            if (i_op.sign && (i_op.exp == EXP_SAT) && w_frac_zero) begin
                // -2^15 is the one e==15 value that int16 represents exactly.
                o_preset_val = INT16_MIN;
                o_preset_v   = 1'b0;
            end else begin
                o_preset_val = i_op.sign ? INT16_MIN : INT16_MAX;
                o_preset_v   = 1'b1;
            end
        end else if (i_op.exp >= EXP_LSH) begin
            o_shift_left = 1'b1;
            o_cnt        = w_lsh_cnt;
        end else if (i_op.exp >= EXP_UNITY) begin
            o_shift_left = 1'b0;
            o_cnt        = w_rsh_cnt;
        end else begin
            // |x| < 1 (including zero and subnormals) truncates to zero;
            // only an exact zero is free of discarded bits.
            o_class    = CLS_ZERO;
            o_preset_c = (i_op.exp != '0) || !w_frac_zero;
        end
    end

endmodule

// File: rtl/fpu_fp2int16.sv
// ---------------------------------------------------------------------------
// fpu_fp2int16
// Multi-cycle FP16 -> signed int16 converter. An accepted operand is
// classified, its significand {1,frac} is aligned one bit per cycle, and the
// sign is applied when the shift count reaches zero. Result and {Z,C,N,V}
// condition codes are held until the consumer takes them.
// Ports:
//   clock   system clock
//   reset   asynchronous, active-high reset
//   bus     fpu_fp2int16_if.slave: inValid/inReady/fpuIn operand channel,
//           outValid/outReady/intOut/condCodes result channel
// Timing: outValid rises cnt+1 cycles after the accept edge; one operation
// is in flight at a time.
// Build option: define FPU_F2I_ROUND_EN for round-to-nearest-even at
// finalise; otherwise the result truncates toward zero and guard/sticky only
// set the C flag.
// ---------------------------------------------------------------------------
module fpu_fp2int16
    import fpu_fp2int16_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    fpu_fp2int16_if.slave  bus
);

    // -----------------------------------------------------------------------
    // Classifier
    // -----------------------------------------------------------------------
    f2iClass_t   w_class;
    logic        w_shift_left;
    logic [3:0]  w_cnt;
    logic [15:0] w_preset_val;
    logic        w_preset_c;
    logic        w_preset_v;

    fpu_fp2int16_classify u_classify (
        .i_op         (bus.fpuIn),
        .o_class      (w_class),
        .o_shift_left (w_shift_left),
        .o_cnt        (w_cnt),
        .o_preset_val (w_preset_val),
        .o_preset_c   (w_preset_c),
        .o_preset_v   (w_preset_v)
    );

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    f2iState_t   r_state;
    f2iState_t   w_state_next;

    logic [15:0] r_mag;         // aligned magnitude
    logic        r_guard;       // first bit shifted out on the right
    logic        r_sticky;      // OR of every bit below the guard
    logic [3:0]  r_cnt;
    logic        r_shift_left;
    logic        r_sign;
    logic        r_special;     // result comes from the classifier presets
    logic [15:0] r_preset_val;
    logic        r_preset_c;
    logic        r_preset_v;
    logic [15:0] r_int_out;
    condCode_t   r_cond;

    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_shift;
    logic        w_finalise;

    // -----------------------------------------------------------------------
    // FSM next-state / control
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_finalise   = 1'b0;

        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.inValid) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt != 4'd0) begin
                    w_shift = 1'b1;
                end else begin
                    w_finalise   = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.outReady) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Finalise: optional rounding, sign application, saturation
    // -----------------------------------------------------------------------
    logic [16:0] w_mag_rnd;     // one extra bit to see a rounding carry
    logic        w_inexact;
    logic [15:0] w_result;
    logic        w_res_c;
    logic        w_res_v;

    assign w_inexact = r_guard | r_sticky;

`ifdef FPU_F2I_ROUND_EN
    logic w_round_up;
    // Nearest-even: round up above half, or at exactly half when LSB is odd.
    assign w_round_up = r_guard & (r_sticky | r_mag[0]);
    assign w_mag_rnd  = {1'b0, r_mag} + {16'd0, w_round_up};
`else
    assign w_mag_rnd  = {1'b0, r_mag};
`endif

    always_comb begin
        w_result = 16'h0000;
        w_res_c  = 1'b0;
        w_res_v  = 1'b0;

        if (r_special) begin
            w_result = r_preset_val;
            w_res_c  = r_preset_c;
            w_res_v  = r_preset_v;
        end else if (!r_sign && (w_mag_rnd > {1'b0, INT16_MAX})) begin
            w_result = INT16_MAX;
            w_res_c  = w_inexact;
            w_res_v  = 1'b1;
        end else if (r_sign && (w_mag_rnd > {1'b0, INT16_MIN})) begin
            w_result = INT16_MIN;
            w_res_c  = w_inexact;
            w_res_v  = 1'b1;
        end else begin
            // A magnitude of exactly 0x8000 negates to itself, i.e. -32768.
            w_result = r_sign ? (16'h0000 - w_mag_rnd[15:0]) : w_mag_rnd[15:0];
            w_res_c  = w_inexact;
            w_res_v  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mag        <= 16'h0000;
            r_guard      <= 1'b0;
            r_sticky     <= 1'b0;
            r_cnt        <= 4'd0;
            r_shift_left <= 1'b0;
            r_sign       <= 1'b0;
            r_special    <= 1'b0;
            r_preset_val <= 16'h0000;
            r_preset_c   <= 1'b0;
            r_preset_v   <= 1'b0;
            r_int_out    <= 16'h0000;
            r_cond       <= '0;
        end else begin
            if (w_accept) begin
                r_mag        <= {5'd0, 1'b1, bus.fpuIn.frac};
                r_guard      <= 1'b0;
                r_sticky     <= 1'b0;
                r_cnt        <= w_cnt;
                r_shift_left <= w_shift_left;
                r_sign       <= bus.fpuIn.sign;
                r_special    <= (w_class != CLS_NORMAL);
                r_preset_val <= w_preset_val;
                r_preset_c   <= w_preset_c;
                r_preset_v   <= w_preset_v;
            end else if (w_shift) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_shift_left) begin
                    r_mag <= {r_mag[14:0], 1'b0};
                end else begin
                    // The old guard joins the sticky bit as the new bit drops in.
                    r_mag    <= {1'b0, r_mag[15:1]};
                    r_guard  <= r_mag[0];
                    r_sticky <= r_sticky | r_guard;
                end
            end

            if (w_finalise) begin
                r_int_out <= w_result;
                r_cond    <= make_cc(w_result, w_res_c, w_res_v);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.inReady   = w_in_ready;
    assign bus.outValid  = w_out_valid;
    assign bus.intOut    = r_int_out;
    assign bus.condCodes = r_cond;

endmodule

// File: tb/tb_fpu_fp2int16.sv
// ---------------------------------------------------------------------------
// tb_fpu_fp2int16
// Directed, table-driven bench for fpu_fp2int16 with hand-computed results,
// plus hand-written backpressure and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_fpu_fp2int16;
    import fpu_fp2int16_pkg::*;

`ifdef FPU_F2I_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk;
    logic rst;

    fpu_fp2int16_if bus_if ();

    fpu_fp2int16 dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] op;
        logic [15:0] exp_int;
        logic [3:0]  exp_cc;   // {Z,C,N,V}
        logic [3:0]  cc_mask;  // bits of condCodes that are checked
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Waits for outValid counting edges since the accept edge.
    task automatic wait_result(output int lat, output logic ok);
        lat = 0;
        while (!bus_if.outValid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = bus_if.outValid;
    endtask

    task automatic run_op(input logic [15:0] op, output logic [15:0] res,
                          output logic [3:0] cc, output int lat, output logic ok);
        int n;
        n = 0;
        ok = 1'b0;
        res = 16'h0;
        cc = 4'h0;
        lat = -1;
        while (!bus_if.inReady && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_if.inReady) begin
            timeout_fail("in_ready_wait");
            return;
        end
        bus_if.inValid = 1'b1;
        bus_if.fpuIn   = op;
        @(posedge clk); #1;
        bus_if.inValid = 1'b0;
        wait_result(lat, ok);
        if (!ok) begin
            timeout_fail("out_valid_wait");
            return;
        end
        res = bus_if.intOut;
        cc  = bus_if.condCodes;
        bus_if.outReady = 1'b1;
        @(posedge clk); #1;
        bus_if.outReady = 1'b0;
    endtask

    initial begin
        logic [15:0] res;
        logic [3:0]  cc;
        int          lat;
        logic        ok;

        //           op        int       ZCNV     mask     lat
        vecs.push_back('{16'h3C00, 16'h0001, 4'b0000, 4'b1111, 11}); // 1.0
        vecs.push_back('{16'hC900, 16'hFFF6, 4'b0010, 4'b1111, 8});  // -10.0
        vecs.push_back('{16'h0000, 16'h0000, 4'b1000, 4'b1111, 1});  // +0
        vecs.push_back('{16'h7BFF, 16'h7FFF, 4'b0001, 4'b1011, 1});  // 65504 sat
        vecs.push_back('{16'hF800, 16'h8000, 4'b0010, 4'b1111, 1});  // -32768 exact
        vecs.push_back('{16'h7E00, 16'h8000, 4'b0011, 4'b1011, 1});  // NaN
        vecs.push_back('{16'h3E00, RND ? 16'h0002 : 16'h0001, 4'b0100, 4'b1111, 11}); // 1.5
        vecs.push_back('{16'h4100, 16'h0002, 4'b0100, 4'b1111, 10}); // 2.5 tie->even
        vecs.push_back('{16'h7C00, 16'h7FFF, 4'b0001, 4'b1011, 1});  // +Inf
        vecs.push_back('{16'hFC00, 16'h8000, 4'b0011, 4'b1011, 1});  // -Inf
        vecs.push_back('{16'h3800, 16'h0000, 4'b1100, 4'b1111, 1});  // 0.5
        vecs.push_back('{16'h0001, 16'h0000, 4'b1100, 4'b1111, 1});  // subnormal
        vecs.push_back('{16'h8000, 16'h0000, 4'b1000, 4'b1111, 1});  // -0
        vecs.push_back('{16'h7800, 16'h7FFF, 4'b0001, 4'b1011, 1});  // 32768 sat
        vecs.push_back('{16'h77FF, 16'h7FF0, 4'b0000, 4'b1111, 5});  // 32752, 4 left shifts
        vecs.push_back('{16'hC500, 16'hFFFB, 4'b0010, 4'b1111, 9});  // -5.0
        vecs.push_back('{16'hBE00, RND ? 16'hFFFE : 16'hFFFF, 4'b0110, 4'b1111, 11}); // -1.5
        vecs.push_back('{16'h3D00, 16'h0001, 4'b0100, 4'b1111, 11}); // 1.25 sticky only
        vecs.push_back('{16'h4300, RND ? 16'h0004 : 16'h0003, 4'b0100, 4'b1111, 10}); // 3.5
        vecs.push_back('{16'h6400, 16'h0400, 4'b0000, 4'b1111, 1});  // 1024, no shift

        rst = 1'b1;
        bus_if.inValid  = 1'b0;
        bus_if.fpuIn    = '0;
        bus_if.outReady = 1'b0;

        #12;
        check("reset_inReady",  32'(bus_if.inReady), 32'd1);
        check("reset_outValid", 32'(bus_if.outValid), 32'd0);
        check("reset_intOut",   32'(bus_if.intOut), 32'd0);
        check("reset_cc",       32'(bus_if.condCodes), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            run_op(vecs[i].op, res, cc, lat, ok);
            if (ok) begin
                $display("vec %0d: op=0x%04h int=0x%04h cc=%b lat=%0d (want 0x%04h %b %0d)",
                         i, vecs[i].op, res, cc, lat, vecs[i].exp_int, vecs[i].exp_cc, vecs[i].exp_lat);
                check($sformatf("v%0d_int", i), 32'(res), 32'(vecs[i].exp_int));
                check($sformatf("v%0d_cc", i), 32'(cc & vecs[i].cc_mask),
                      32'(vecs[i].exp_cc & vecs[i].cc_mask));
                check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            end
        end

        // ---------------- backpressure in DONE ----------------
        bus_if.inValid = 1'b1;
        bus_if.fpuIn   = 16'h4500;               // 5.0
        @(posedge clk); #1;
        bus_if.fpuIn   = 16'h3C00;               // keep offering 1.0 while busy
        wait_result(lat, ok);
        if (!ok) begin
            timeout_fail("bp_wait");
        end else begin
            check("bp_lat", 32'(lat), 32'd9);
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                $display("backpressure cycle %0d: outValid=%b inReady=%b int=0x%04h cc=%b",
                         k, bus_if.outValid, bus_if.inReady, bus_if.intOut, bus_if.condCodes);
                check("bp_outValid", 32'(bus_if.outValid), 32'd1);
                check("bp_inReady",  32'(bus_if.inReady), 32'd0);
                check("bp_intOut",   32'(bus_if.intOut), 32'h0005);
                check("bp_cc",       32'(bus_if.condCodes), 32'b0000);
            end
            bus_if.outReady = 1'b1;
            @(posedge clk); #1;
            bus_if.outReady = 1'b0;
            check("bp_release_outValid", 32'(bus_if.outValid), 32'd0);
            check("bp_release_inReady",  32'(bus_if.inReady), 32'd1);
            @(posedge clk); #1;                  // accepts the pending 1.0
            bus_if.inValid = 1'b0;
            check("bp_accept_inReady", 32'(bus_if.inReady), 32'd0);
            wait_result(lat, ok);
            if (!ok) begin
                timeout_fail("bp_next_wait");
            end else begin
                $display("after backpressure: int=0x%04h lat=%0d", bus_if.intOut, lat);
                check("bp_next_int", 32'(bus_if.intOut), 32'h0001);
                check("bp_next_lat", 32'(lat), 32'd11);
                bus_if.outReady = 1'b1;
                @(posedge clk); #1;
                bus_if.outReady = 1'b0;
            end
        end
        bus_if.inValid = 1'b0;

        // ---------------- asynchronous reset mid-SHIFT ----------------
        bus_if.inValid = 1'b1;
        bus_if.fpuIn   = 16'h3C00;
        @(posedge clk); #1;
        bus_if.inValid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        $display("mid-shift reset: inReady=%b outValid=%b int=0x%04h cc=%b",
                 bus_if.inReady, bus_if.outValid, bus_if.intOut, bus_if.condCodes);
        check("arst_inReady",  32'(bus_if.inReady), 32'd1);
        check("arst_outValid", 32'(bus_if.outValid), 32'd0);
        check("arst_intOut",   32'(bus_if.intOut), 32'd0);
        check("arst_cc",       32'(bus_if.condCodes), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(16'h4500, res, cc, lat, ok);
        if (ok) begin
            $display("post-reset op 0x4500: int=0x%04h cc=%b lat=%0d", res, cc, lat);
            check("arst_next_int", 32'(res), 32'h0005);
            check("arst_next_cc",  32'(cc), 32'b0000);
            check("arst_next_lat", 32'(lat), 32'd9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
